pla_stim_capture: RTL and testbench
===================================

# pla_stim_capture

Self-checking stimulus/response engine for the combinational PLA benchmarks used in power-aware synthesis training. It generates pseudo-random input vectors with an LFSR and drives them into a benchmark netlist. It then takes the benchmark outputs back, compacts them into a MISR signature and counts output bit toggles as a switching-activity proxy. It sits between the run controller and the benchmark under evaluation, on the opposite end of the benchmark's input/output interface.

## Interface
- IN_W, 27, stimulus width (benchmark input count)
- OUT_W, 6, response width (benchmark output count), OUT_W <= SIG_W
- SIG_W, 16, signature width
- CNT_W, 16, vector counter width
- LFSR_TAPS, 27'h4000013, Fibonacci feedback mask (x^27+x^5+x^2+x+1)
- MISR_TAPS, 16'hD008, MISR feedback mask (x^16+x^15+x^13+x^4+1)
- clk  in  1  clock; all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  begin run; sampled only in IDLE
- num_vec  in  CNT_W  vectors to issue; sampled with start
- seed  in  IN_W  LFSR seed; sampled with start
- stim_o  out  IN_W  current vector (registered)
- stim_valid  out  1  stim_o valid
- stim_ready  in  1  consumer accepts stim_o
- resp_i  in  OUT_W  benchmark response
- resp_valid  in  1  resp_i valid; single-cycle pulse; no backpressure
- busy  out  1  high in RUN and DRAIN
- done  out  1  one-cycle pulse at run end
- signature  out  SIG_W  MISR state
- toggle_cnt  out  32  accumulated output toggles
- vec_cnt  out  CNT_W  responses accepted this run

## Operation
- FSM: IDLE, RUN, DRAIN, DONE.
- IDLE: on start, load LFSR with seed; a seed of 0 is replaced by 1. Clear signature, toggle_cnt, vec_cnt, prev_resp and the issue counter.
  - If num_vec == 0, go to DONE.
  - Otherwise go to RUN.
- RUN: stim_valid=1. On stim_valid & stim_ready:
  - LFSR steps: fb = ^(state & LFSR_TAPS); next = {state[IN_W-2:0], fb}.
  - Issue counter increments.
  - When the issue counter reaches num_vec, deassert stim_valid and go to DRAIN, or directly to DONE if all responses are already in.
- Response accepted when resp_valid and vec_cnt < num_vec, in RUN or DRAIN. Responses in IDLE/DONE or beyond num_vec are ignored.
  - MISR: fb = ^(signature & MISR_TAPS); signature <= {signature[SIG_W-2:0], fb} ^ zero_ext(resp_i).
  - toggle_cnt += popcount(resp_i ^ prev_resp), saturating at 32'hFFFFFFFF; prev_resp <= resp_i.
  - vec_cnt increments.
- DRAIN: when vec_cnt reaches num_vec, go to DONE.
- DONE: done=1 for one cycle, then go to IDLE.
  - signature, toggle_cnt and vec_cnt hold until the next accepted start.
- start while busy or in DONE is ignored.
- When stim_ready is low, stim_o and the LFSR hold.

## Timing
- Reset values:
  - stim_o = 0, stim_valid = 0, busy = 0, done = 0.
  - signature = 0, toggle_cnt = 0, vec_cnt = 0, prev_resp = 0.
  - State = IDLE.
- start sampled in cycle T: stim_o = seed (or 1) with stim_valid = 1 and busy = 1 from T+1.
- Issue throughput: one vector per cycle while stim_ready = 1.
- Last response accepted in cycle T: vec_cnt, signature and toggle_cnt are updated at T+1, and done is asserted at T+1.
- num_vec == 0: done at T+1 after start; busy never asserts.
- Response and issue in the same cycle are both processed.
- Reset asserted mid-run aborts immediately to reset values; no done pulse is produced.

## Configuration
- STIMCAP_TOGGLE_EN defined: toggle counter, prev_resp register and popcount logic are built as described.
- STIMCAP_TOGGLE_EN undefined: toggle_cnt is tied to 0 and no toggle logic is built. The FSM, stimulus path and MISR are unchanged.

## Test plan
- seed=0, num_vec=2, stim_ready=1 -> stim_o=27'h0000001, then 27'h0000003; stim_valid falls after 2 cycles.
- num_vec=0 with start -> done one cycle later, busy stays 0, signature=0, vec_cnt=0.
- num_vec=2, resp_i=6'h3F for both responses -> signature 16'h003F after the first, 16'h0040 after the second; toggle_cnt=6 (12 if the second response is 6'h00), and done follows the second response.
- num_vec=4, responses alternating 6'h3F/6'h00 -> toggle_cnt=24, vec_cnt=4; a fifth resp_valid pulse is ignored.
- stim_ready held low 5 cycles mid-run -> stim_o and the LFSR hold, then resume on the same vector. A start pulse during the run is ignored.
- rst asserted during DRAIN -> all outputs return to reset values at once with no done pulse; a new start runs normally.

Source files
------------

// File: rtl/pla_stim_capture_if.sv
// pla_stim_capture_if: stimulus/response channel between the capture engine
// (master) and the PLA benchmark under evaluation (slave).
interface pla_stim_capture_if #(
    parameter int IN_W  = 27,
    parameter int OUT_W = 6
);
    logic [IN_W-1:0]  stim_o;
    logic             stim_valid;
    logic             stim_ready;
    logic [OUT_W-1:0] resp_i;
    logic             resp_valid;

    // Engine side: drives vectors out, takes responses back.
    modport master (
        output stim_o,
        output stim_valid,
        input  stim_ready,
        input  resp_i,
        input  resp_valid
    );

    // Benchmark side: consumes vectors, returns responses.
    modport slave (
        input  stim_o,
        input  stim_valid,
        output stim_ready,
        output resp_i,
        output resp_valid
    );
endinterface

// File: rtl/pla_stim_capture.sv
// pla_stim_capture: LFSR stimulus generator and MISR response compactor for
// combinational PLA benchmarks, with an optional output-toggle counter.
// Optional feature macro: STIMCAP_TOGGLE_EN (defined -> toggle counter built,
// undefined -> toggle_cnt tied to 0).
module pla_stim_capture #(
    parameter int               IN_W      = 27,
    parameter int               OUT_W     = 6,
    parameter int               SIG_W     = 16,
    parameter int               CNT_W     = 16,
    parameter logic [IN_W-1:0]  LFSR_TAPS = 27'h4000013,
    parameter logic [SIG_W-1:0] MISR_TAPS = 16'hD008
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [CNT_W-1:0]   num_vec,
    input  logic [IN_W-1:0]    seed,
    pla_stim_capture_if.master bus,
    output logic               busy,
    output logic               done,
    output logic [SIG_W-1:0]   signature,
    output logic [31:0]        toggle_cnt,
    output logic [CNT_W-1:0]   vec_cnt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [IN_W-1:0]  lfsr_q, lfsr_d;
    logic [CNT_W-1:0] num_q, num_d;
    logic [CNT_W-1:0] issue_q, issue_d;
    logic [CNT_W-1:0] vec_q, vec_d;
    logic [SIG_W-1:0] sig_q, sig_d;
    logic             stim_valid_c;

    logic start_acc;   // start taken in IDLE
    logic issue_fire;  // vector handed to the benchmark this cycle
    logic resp_acc;    // response folded into the signature this cycle

    assign start_acc  = (state_q == S_IDLE) && start;
    assign issue_fire = (state_q == S_RUN) && bus.stim_ready;
    assign resp_acc   = ((state_q == S_RUN) || (state_q == S_DRAIN))
                        && bus.resp_valid && (vec_q < num_q);

    // Datapath next-state: seed/clear on start, LFSR step on issue, MISR fold on response.
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path infers a latch.
        lfsr_d  = lfsr_q;
        num_d   = num_q;
        issue_d = issue_q;
        vec_d   = vec_q;
        sig_d   = sig_q;
        if (start_acc) begin
            lfsr_d  = (seed == '0) ? IN_W'(1) : seed;
            num_d   = num_vec;
            issue_d = '0;
            vec_d   = '0;
            sig_d   = '0;
        end else begin
            if (issue_fire) begin
                lfsr_d  = {lfsr_q[IN_W-2:0], ^(lfsr_q & LFSR_TAPS)};
                issue_d = issue_q + CNT_W'(1);
            end
            if (resp_acc) begin
                sig_d = {sig_q[SIG_W-2:0], ^(sig_q & MISR_TAPS)} ^ SIG_W'(bus.resp_i);
                vec_d = vec_q + CNT_W'(1);
            end
        end
    end

    // FSM next-state: the run ends once every vector is issued and every response is in.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = (num_vec == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (issue_fire && (issue_d == num_q)) begin
                    state_d = (vec_d == num_q) ? S_DONE : S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (vec_d == num_q) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs decoded from the registered state only.
    always_comb begin
        stim_valid_c = (state_q == S_RUN);
        busy         = (state_q == S_RUN) || (state_q == S_DRAIN);
        done         = (state_q == S_DONE);
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers; all cleared by reset so a mid-run abort leaves no stale result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q  <= '0;
            num_q   <= '0;
            issue_q <= '0;
            vec_q   <= '0;
            sig_q   <= '0;
        end else begin
            lfsr_q  <= lfsr_d;
            num_q   <= num_d;
            issue_q <= issue_d;
            vec_q   <= vec_d;
            sig_q   <= sig_d;
        end
    end

    assign bus.stim_o     = lfsr_q;
    assign bus.stim_valid = stim_valid_c;
    assign signature      = sig_q;
    assign vec_cnt        = vec_q;

`ifdef STIMCAP_TOGGLE_EN
    logic [OUT_W-1:0] prev_q;
    logic [OUT_W-1:0] diff;
    logic [31:0]      tog_q, tog_d;
    logic [31:0]      pop;
    logic [32:0]      sum;

    assign diff = bus.resp_i ^ prev_q;

    // Toggle accumulator: add the Hamming distance to the previous response, saturating.
    always_comb begin
        tog_d = tog_q;
        pop   = '0;
        for (int i = 0; i < OUT_W; i++) begin
            pop = pop + 32'(diff[i]);
        end
        sum = {1'b0, tog_q} + {1'b0, pop};
        if (start_acc) begin
            tog_d = '0;
        end else if (resp_acc) begin
            tog_d = sum[32] ? '1 : sum[31:0];
        end
    end

    // Toggle counter and previous-response registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tog_q  <= '0;
            prev_q <= '0;
        end else begin
            tog_q <= tog_d;
            if (start_acc) begin
                prev_q <= '0;
            end else if (resp_acc) begin
                prev_q <= bus.resp_i;
            end
        end
    end

    assign toggle_cnt = tog_q;
`else
    assign toggle_cnt = '0;
`endif

endmodule

// File: tb/tb_pla_stim_capture.sv
// tb_pla_stim_capture: directed and randomized checks of pla_stim_capture
// against a transaction-level reference model.
module tb_pla_stim_capture;

    localparam int IN_W  = 27;
    localparam int OUT_W = 6;
    localparam int SIG_W = 16;
    localparam int CNT_W = 16;
`ifdef STIMCAP_TOGGLE_EN
    localparam bit TOG_EN = 1'b1;
`else
    localparam bit TOG_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [CNT_W-1:0] num_vec = '0;
    logic [IN_W-1:0]  seed = '0;
    logic             busy;
    logic             done;
    logic [SIG_W-1:0] signature;
    logic [31:0]      toggle_cnt;
    logic [CNT_W-1:0] vec_cnt;

    pla_stim_capture_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

    pla_stim_capture dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .num_vec    (num_vec),
        .seed       (seed),
        .bus        (bus),
        .busy       (busy),
        .done       (done),
        .signature  (signature),
        .toggle_cnt (toggle_cnt),
        .vec_cnt    (vec_cnt)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model state as seen after the most recent clock edge.
    logic [IN_W-1:0]  m_lfsr;
    logic [SIG_W-1:0] m_sig;
    logic [OUT_W-1:0] m_prev;
    longint           m_tog;
    int               m_cnt;
    int               m_issued;
    int               m_n;
    bit               m_busy;
    bit               m_done;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // x^27+x^5+x^2+x+1: new bit is the XOR of state bits 26, 4, 1, 0.
    function automatic logic [IN_W-1:0] lfsr_next(input logic [IN_W-1:0] s);
        logic b;
        b = s[26] ^ s[4] ^ s[1] ^ s[0];
        return {s[IN_W-2:0], b};
    endfunction

    // x^16+x^15+x^13+x^4+1: feedback from bits 15, 14, 12, 3, response XORed in.
    function automatic logic [SIG_W-1:0] misr_next(input logic [SIG_W-1:0] s,
                                                   input logic [OUT_W-1:0] r);
        logic b;
        b = s[15] ^ s[14] ^ s[12] ^ s[3];
        return {s[SIG_W-2:0], b} ^ {{(SIG_W-OUT_W){1'b0}}, r};
    endfunction

    task automatic model_reset();
        m_lfsr = '0; m_sig = '0; m_prev = '0; m_tog = 0;
        m_cnt = 0; m_issued = 0; m_n = 0; m_busy = 0; m_done = 0;
    endtask

    // Compare every observable output with the model.
    task automatic compare_all();
        longint exp_tog;
        bit     exp_valid;
        exp_tog   = TOG_EN ? m_tog : 0;
        exp_valid = m_busy && (m_issued < m_n);
        check("busy", busy, m_busy);
        check("done", done, m_done);
        check("stim_valid", bus.stim_valid, exp_valid);
        if (exp_valid) check("stim_o", bus.stim_o, m_lfsr);
        check("vec_cnt", vec_cnt, m_cnt);
        check("signature", signature, m_sig);
        check("toggle_cnt", toggle_cnt, exp_tog);
    endtask

    // Drive one cycle of inputs, advance the model across the edge, then compare.
    task automatic step(input bit st, input int n, input logic [IN_W-1:0] sd,
                        input bit rdy, input bit rv, input logic [OUT_W-1:0] r);
        bit idle, run, new_done;
        start = st; num_vec = CNT_W'(n); seed = sd;
        bus.stim_ready = rdy; bus.resp_valid = rv; bus.resp_i = r;
        idle     = !m_busy && !m_done;
        run      = m_busy && (m_issued < m_n);
        new_done = 0;
        if (st && idle) begin
            m_lfsr = (sd == '0) ? IN_W'(1) : sd;
            m_sig = '0; m_tog = 0; m_prev = '0; m_cnt = 0; m_issued = 0; m_n = n;
            if (n == 0) new_done = 1;
            else        m_busy = 1;
        end else if (m_busy) begin
            if (run && rdy) begin
                m_lfsr = lfsr_next(m_lfsr);
                m_issued++;
            end
            if (rv && (m_cnt < m_n)) begin
                m_sig = misr_next(m_sig, r);
                m_tog = m_tog + $countones(r ^ m_prev);
                if (m_tog > 64'hFFFF_FFFF) m_tog = 64'hFFFF_FFFF;
                m_prev = r;
                m_cnt++;
            end
            if ((m_issued == m_n) && (m_cnt == m_n)) begin
                m_busy   = 0;
                new_done = 1;
            end
        end
        m_done = new_done;
        @(posedge clk);
        #1;
        start = 1'b0; bus.resp_valid = 1'b0;
        compare_all();
    endtask

    task automatic idle_step(input bit rdy, input bit rv, input logic [OUT_W-1:0] r);
        step(1'b0, 0, '0, rdy, rv, r);
    endtask

    // Random traffic (with stray start pulses) until the model returns to IDLE.
    task automatic finish_run(input int budget);
        int k;
        k = 0;
        while ((m_busy || m_done) && (k < budget)) begin
            step(($urandom_range(0, 7) == 0), int'($urandom_range(0, 5)), IN_W'($urandom),
                 ($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1, OUT_W'($urandom));
            k++;
        end
        if (m_busy || m_done) check("run_timeout", 1, 0);
    endtask

    initial begin
        bus.stim_ready = 1'b0;
        bus.resp_valid = 1'b0;
        bus.resp_i     = '0;
        model_reset();

        // Reset values.
        repeat (2) @(posedge clk);
        #1;
        check("rst_stim_o", bus.stim_o, 0);
        check("rst_stim_valid", bus.stim_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_sig", signature, 0);
        check("rst_tog", toggle_cnt, 0);
        check("rst_vec", vec_cnt, 0);
        rst = 1'b0;

        // seed 0 becomes 1; two vectors then valid drops; two 3F responses.
        step(1'b1, 2, '0, 1'b1, 1'b0, '0);
        check("p1_vec0", bus.stim_o, 27'h0000001);
        idle_step(1'b1, 1'b0, '0);
        check("p1_vec1", bus.stim_o, 27'h0000003);
        idle_step(1'b1, 1'b0, '0);
        check("p1_valid_fall", bus.stim_valid, 0);
        idle_step(1'b1, 1'b1, 6'h3F);
        check("p3_sig1", signature, 16'h003F);
        check("p3_done_early", done, 0);
        idle_step(1'b1, 1'b1, 6'h3F);
        check("p3_sig2", signature, 16'h0040);
        check("p3_done", done, 1);
        check("p3_tog", toggle_cnt, TOG_EN ? 6 : 0);
        idle_step(1'b1, 1'b0, '0);

        // num_vec == 0: done next cycle, never busy, results cleared.
        step(1'b1, 0, 27'h5, 1'b1, 1'b0, '0);
        check("p2_done", done, 1);
        check("p2_busy", busy, 0);
        check("p2_sig", signature, 0);
        check("p2_vec", vec_cnt, 0);
        idle_step(1'b1, 1'b0, '0);

        // Alternating 3F/00 responses issued alongside the vectors; extra pulses ignored.
        step(1'b1, 4, IN_W'($urandom), 1'b1, 1'b0, '0);
        for (int i = 0; i < 4; i++) idle_step(1'b1, 1'b1, (i % 2 == 0) ? 6'h3F : 6'h00);
        check("p4_done", done, 1);
        check("p4_vec", vec_cnt, 4);
        check("p4_tog", toggle_cnt, TOG_EN ? 24 : 0);
        idle_step(1'b1, 1'b1, 6'h3F);
        idle_step(1'b1, 1'b1, 6'h15);
        check("p4_vec_hold", vec_cnt, 4);
        check("p4_tog_hold", toggle_cnt, TOG_EN ? 24 : 0);

        // stim_ready low for 5 cycles mid-run; a start pulse in the stall is ignored.
        step(1'b1, 10, 27'h0ABCDEF, 1'b1, 1'b0, '0);
        idle_step(1'b1, 1'b1, 6'h2A);
        idle_step(1'b1, 1'b0, '0);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) step(1'b1, 3, 27'h1234, 1'b0, 1'b1, 6'h11);
            else        idle_step(1'b0, 1'b0, '0);
        end
        finish_run(400);

        // Reset during DRAIN aborts immediately with no done pulse.
        step(1'b1, 6, 27'h7654321, 1'b1, 1'b1, 6'h05);
        for (int i = 0; i < 6; i++) idle_step(1'b1, 1'b0, '0);
        check("p6_in_drain", busy && !bus.stim_valid, 1);
        #2;
        rst = 1'b1;
        #1;
        check("p6_rst_busy", busy, 0);
        check("p6_rst_done", done, 0);
        check("p6_rst_stim_o", bus.stim_o, 0);
        check("p6_rst_valid", bus.stim_valid, 0);
        check("p6_rst_sig", signature, 0);
        check("p6_rst_vec", vec_cnt, 0);
        check("p6_rst_tog", toggle_cnt, 0);
        @(posedge clk);
        #1;
        check("p6_no_done", done, 0);
        rst = 1'b0;
        model_reset();
        step(1'b1, 3, 27'h00000F0, 1'b1, 1'b0, '0);
        finish_run(400);

        // Randomized runs.
        for (int run_i = 0; run_i < 10; run_i++) begin
            step(1'b1, int'($urandom_range(0, 20)),
                 ($urandom_range(0, 3) == 0) ? '0 : IN_W'($urandom),
                 ($urandom_range(0, 3) != 0), 1'b0, '0);
            finish_run(600);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global watchdog.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule
